// File: rtl/imem_loader_arb.sv
// imem_loader_arb: owns the single-port instruction RAM and arbitrates it
// between CPU instruction fetch and an external loader. A programming
// session holds the CPU in reset, hands the loader exclusive read/write
// access, and then releases the CPU after HOLD_CYC cycles.
module imem_loader_arb #(
  parameter int AW       = 8,
  parameter int HOLD_CYC = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cpu_req,
  input  logic [31:0]   cpu_addr,
  output logic [15:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_hold,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [15:0]   ld_wdata,
  output logic [15:0]   ld_rdata,
  output logic          ld_rvalid,
  input  logic          prog_start,
  input  logic          prog_done,
  output logic [AW:0]   wr_count,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, PROG, RELEASE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   hold_cnt;
  logic            cpu_grant;
  logic            cpu_oor;
  logic            ld_rd_grant;
  logic            ld_wr_grant;
  logic            oor_p1;
  logic            unused_bits;

  // Write counter saturates rather than wrapping so a runaway loader is visible.
  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Bit 0 of the byte address selects a byte within the halfword; not needed.
  assign unused_bits = cpu_addr[0];
  assign cpu_oor     = |cpu_addr[31:AW+1];
  assign ld_rd_grant = ld_ready & ~ld_we;
  assign ld_wr_grant = ld_ready & ld_we;
  assign mem_wdata   = ld_wdata;

  // Out-of-range fetches return zero so the core sees a harmless opcode.
  assign cpu_rdata = oor_p1 ? 16'h0000 : mem_rdata;
  assign ld_rdata  = mem_rdata;

  // Next-state and RAM port steering; the CPU has fixed priority in RUN.
  always_comb begin
    state_nxt = state;
    cpu_grant = 1'b0;
    ld_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ld_addr;
    case (state)
      RUN: begin
        cpu_grant = cpu_req;
        if (cpu_req) begin
          mem_en   = ~cpu_oor;
          mem_addr = cpu_addr[AW:1];
        end else if (ld_valid && !ld_we) begin
          ld_ready = 1'b1;
          mem_en   = 1'b1;
        end
        if (prog_start) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = PROG;
      end
      PROG: begin
        ld_ready = ld_valid;
        mem_en   = ld_valid;
        mem_we   = ld_valid & ld_we;
        if (prog_done) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (hold_cnt == '0) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= RUN;
    else          state <= state_nxt;
  end

  // Read-valid flags and CPU hold, all one cycle behind the grant decision.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cpu_ready <= 1'b0;
      ld_rvalid <= 1'b0;
      cpu_hold  <= 1'b0;
    end else begin
      cpu_ready <= cpu_grant;
      ld_rvalid <= ld_rd_grant;
      cpu_hold  <= (state_nxt != RUN);
    end
  end

  // Range flag travels with the fetch to mask the returned data.
  always_ff @(posedge HCLK) begin
    oor_p1 <= cpu_grant & cpu_oor;
  end

  // Release hold counter: loaded on RELEASE entry, counts down to zero.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_cnt <= '0;
    end else if (state != RELEASE && state_nxt == RELEASE) begin
      hold_cnt <= CW'(HOLD_CYC - 1);
    end else if (state == RELEASE && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Session write counter: cleared when a session starts, kept afterwards.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_count <= '0;
    end else if (state == RUN && state_nxt == DRAIN) begin
      wr_count <= '0;
    end else if (ld_wr_grant) begin
      wr_count <= sat_inc(wr_count);
    end
  end

endmodule
